// File: rtl/btb_pkg.sv
// btb_pkg: shared entry type, flush FSM state and address helpers for btb_assoc.
package btb_pkg;

  localparam int BTB_ADDR_LEN = 32;
  localparam int BTB_IDX_SEL  = 6;
  localparam int BTB_TAG_LEN  = BTB_ADDR_LEN - 3 - BTB_IDX_SEL;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_LEN-1:0]  tag;
    logic                    slot;
    logic [BTB_ADDR_LEN-1:0] target;
  } btb_entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } btb_state_e;

  // Set index sits just above the 8-byte fetch-group offset.
  function automatic logic [63:0] btb_idx(logic [63:0] addr, int idx_sel = BTB_IDX_SEL);
    return (addr >> 3) & ((64'd1 << idx_sel) - 64'd1);
  endfunction

  function automatic logic [63:0] btb_tag(logic [63:0] addr, int idx_sel = BTB_IDX_SEL);
    return addr >> (3 + idx_sel);
  endfunction

endpackage

// File: rtl/btb_way.sv
// btb_way: storage for one way of the BTB; registered lookup read, combinational
// read of the update set, write port and single-set valid clear.
module btb_way
  import btb_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int IDX_SEL  = 6,
  parameter int TAG_W    = ADDR_LEN - 3 - IDX_SEL
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rd_en,
  input  logic [IDX_SEL-1:0]  rd_idx,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic                rd_slot,
  output logic [ADDR_LEN-1:0] rd_target,
  input  logic [IDX_SEL-1:0]  wr_idx,
  output logic                ws_valid,
  output logic [TAG_W-1:0]    ws_tag,
  output logic                ws_slot,
  input  logic                wr_en,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic                wr_slot,
  input  logic [ADDR_LEN-1:0] wr_target,
  input  logic                clr_en,
  input  logic [IDX_SEL-1:0]  clr_idx
);

  localparam int SETS = 1 << IDX_SEL;

  logic [SETS-1:0]     valid;
  logic [SETS-1:0]     slot_mem;
  logic [TAG_W-1:0]    tag_mem [SETS];
  logic [ADDR_LEN-1:0] tgt_mem [SETS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (clr_en)     valid[clr_idx] <= 1'b0;
      else if (wr_en) valid[wr_idx]  <= 1'b1;
      rd_valid <= rd_en & valid[rd_idx];
    end
  end

  // Payload needs no reset: it is only ever qualified by valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      slot_mem[wr_idx] <= wr_slot;
      tgt_mem[wr_idx]  <= wr_target;
    end
    rd_tag    <= tag_mem[rd_idx];
    rd_slot   <= slot_mem[rd_idx];
    rd_target <= tgt_mem[rd_idx];
  end

  assign ws_valid = valid[wr_idx];
  assign ws_tag   = tag_mem[wr_idx];
  assign ws_slot  = slot_mem[wr_idx];

endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: N-way set-associative BTB for a two-slot fetch group, one-cycle lookup,
// round-robin replacement. Define BTB_FLUSH_EN to build the sequenced table flush.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int IDX_SEL  = 6,
  parameter int WAYS     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_LEN-1:0] pc,
  input  logic                invalid2,
  output logic                hit,
  output logic                hit_slot,
  output logic [ADDR_LEN-1:0] jmpaddr,
  input  logic                we,
  input  logic [ADDR_LEN-1:0] jmpsrc,
  input  logic [ADDR_LEN-1:0] jmpdst,
  input  logic                flush,
  output logic                busy
);

  localparam int TAG_W = ADDR_LEN - 3 - IDX_SEL;
  localparam int SETS  = 1 << IDX_SEL;
  localparam int VW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic                flush_go, clr_en, wr_go, rd_en, replace;
  logic [IDX_SEL-1:0]  clr_idx, pc_idx, wr_idx;
  logic [TAG_W-1:0]    pc_tag, wr_tag;
  logic [VW-1:0]       way_sel, free_sel, victim_cur;
  logic                match_any, free_any;

  logic [WAYS-1:0]     rd_valid, rd_slot, ws_valid, ws_slot;
  logic [TAG_W-1:0]    rd_tag [WAYS];
  logic [TAG_W-1:0]    ws_tag [WAYS];
  logic [ADDR_LEN-1:0] rd_target [WAYS];

  logic [TAG_W-1:0]    tag_q;
  logic                pc2_q, inv2_q;
  logic                hit0, hit1;
  logic [ADDR_LEN-1:0] tgt0, tgt1;

`ifdef BTB_FLUSH_EN
  // state    | meaning
  // ST_IDLE  | normal lookup and update
  // ST_FLUSH | clearing set `sweep` this cycle; updates dropped, hits masked
  btb_state_e         state, state_nx;
  logic [IDX_SEL-1:0] sweep, sweep_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      sweep <= '0;
    end else begin
      state <= state_nx;
      sweep <= sweep_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sweep_nx = sweep;
    flush_go = 1'b0;
    clr_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (flush) begin
          state_nx = ST_FLUSH;
          sweep_nx = '0;
          flush_go = 1'b1;
        end
      end
      ST_FLUSH: begin
        clr_en   = 1'b1;
        sweep_nx = sweep + 1'b1;
        if (&sweep) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy    = (state == ST_FLUSH);
  assign clr_idx = sweep;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign busy     = 1'b0;
  assign flush_go = 1'b0;
  assign clr_en   = 1'b0;
  assign clr_idx  = '0;
`endif

  // A flush request also masks the lookup sampled with it, so hit stays low for the whole sweep.
  assign rd_en = !busy && !flush_go;
  assign wr_go = we && !busy && !flush_go;

  assign pc_idx = IDX_SEL'(btb_idx(64'(pc), IDX_SEL));
  assign pc_tag = TAG_W'(btb_tag(64'(pc), IDX_SEL));
  assign wr_idx = IDX_SEL'(btb_idx(64'(jmpsrc), IDX_SEL));
  assign wr_tag = TAG_W'(btb_tag(64'(jmpsrc), IDX_SEL));

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    btb_way #(
      .ADDR_LEN(ADDR_LEN),
      .IDX_SEL (IDX_SEL),
      .TAG_W   (TAG_W)
    ) u_way (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (rd_en),
      .rd_idx   (pc_idx),
      .rd_valid (rd_valid[g]),
      .rd_tag   (rd_tag[g]),
      .rd_slot  (rd_slot[g]),
      .rd_target(rd_target[g]),
      .wr_idx   (wr_idx),
      .ws_valid (ws_valid[g]),
      .ws_tag   (ws_tag[g]),
      .ws_slot  (ws_slot[g]),
      .wr_en    (wr_go && (way_sel == VW'(g))),
      .wr_tag   (wr_tag),
      .wr_slot  (jmpsrc[2]),
      .wr_target(jmpdst),
      .clr_en   (clr_en),
      .clr_idx  (clr_idx)
    );
  end

  // Descending scans leave the lowest qualifying way selected.
  always_comb begin
    match_any = 1'b0;
    free_any  = 1'b0;
    way_sel   = '0;
    free_sel  = '0;
    replace   = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (ws_valid[w] && ws_tag[w] == wr_tag && ws_slot[w] == jmpsrc[2]) begin
        match_any = 1'b1;
        way_sel   = VW'(w);
      end
      if (!ws_valid[w]) begin
        free_any = 1'b1;
        free_sel = VW'(w);
      end
    end
    if (!match_any) begin
      if (free_any) begin
        way_sel = free_sel;
      end else begin
        way_sel = victim_cur;
        replace = 1'b1;
      end
    end
  end

  if (WAYS > 1) begin : g_victim
    logic [SETS-1:0][VW-1:0] victim;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                victim <= '0;
      else if (clr_en)           victim[clr_idx] <= '0;
      else if (wr_go && replace) victim[wr_idx] <= victim[wr_idx] + 1'b1;
    end

    assign victim_cur = victim[wr_idx];
  end else begin : g_no_victim
    logic unused_replace;
    assign unused_replace = replace;
    assign victim_cur     = '0;
  end

  always_ff @(posedge clk) begin
    tag_q  <= pc_tag;
    pc2_q  <= pc[2];
    inv2_q <= invalid2;
  end

  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    tgt0 = '0;
    tgt1 = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (rd_valid[w] && rd_tag[w] == tag_q) begin
        if (!rd_slot[w] && !pc2_q) begin
          hit0 = 1'b1;
          tgt0 = rd_target[w];
        end
        if (rd_slot[w] && (pc2_q || !inv2_q)) begin
          hit1 = 1'b1;
          tgt1 = rd_target[w];
        end
      end
    end
  end

  // hit_slot is relative to pc: a slot-1 entry seen from pc[2]=1 is the branch at pc itself.
  assign hit      = hit0 || hit1;
  assign hit_slot = !hit0 && hit1 && !pc2_q;
  assign jmpaddr  = hit0 ? tgt0 : (hit1 ? tgt1 : '0);

endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: randomized and directed bench for btb_assoc with a queue-based scoreboard
// against an entry-table reference model; follows BTB_FLUSH_EN like the design.
`timescale 1ns/1ps
module tb_btb_assoc;
  import btb_pkg::*;

  localparam int ADDR_LEN = 32;
  localparam int IDX_SEL  = 6;
  localparam int WAYS     = 2;
  localparam int SETS     = 1 << IDX_SEL;
`ifdef BTB_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [ADDR_LEN-1:0] pc = '0;
  logic                invalid2 = 1'b0;
  logic                hit, hit_slot, busy;
  logic [ADDR_LEN-1:0] jmpaddr;
  logic                we = 1'b0;
  logic [ADDR_LEN-1:0] jmpsrc = '0;
  logic [ADDR_LEN-1:0] jmpdst = '0;
  logic                flush = 1'b0;

  btb_assoc #(.ADDR_LEN(ADDR_LEN), .IDX_SEL(IDX_SEL), .WAYS(WAYS)) dut (
    .clk(clk), .reset(reset), .pc(pc), .invalid2(invalid2), .hit(hit), .hit_slot(hit_slot),
    .jmpaddr(jmpaddr), .we(we), .jmpsrc(jmpsrc), .jmpdst(jmpdst), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          hit;
    bit          slot;
    logic [31:0] addr;
    bit          busy;
  } exp_t;

  exp_t       expq[$];
  int         checks = 0;
  int         errors = 0;
  btb_entry_t mdl [SETS][WAYS];
  int         vptr [SETS];
  int         busy_left = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      vptr[s] = 0;
      for (int w = 0; w < WAYS; w++) mdl[s][w].valid = 1'b0;
    end
  endtask

  task automatic model_lookup(input logic [31:0] p, input bit i2, inout exp_t e);
    int st;
    bit g0, g1;
    logic [31:0] a0, a1;
    st = int'(p[3 +: IDX_SEL]);
    g0 = 0; g1 = 0; a0 = '0; a1 = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (mdl[st][w].valid && mdl[st][w].tag == p[ADDR_LEN-1:3+IDX_SEL]) begin
        if (!mdl[st][w].slot && !p[2] && !g0) begin g0 = 1; a0 = mdl[st][w].target; end
        if (mdl[st][w].slot && (p[2] || !i2) && !g1) begin g1 = 1; a1 = mdl[st][w].target; end
      end
    end
    e.hit  = g0 || g1;
    e.slot = !g0 && g1 && !p[2];
    e.addr = g0 ? a0 : (g1 ? a1 : '0);
  endtask

  task automatic model_write(input logic [31:0] s, input logic [31:0] d);
    int st, pick;
    btb_entry_t ne;
    st = int'(s[3 +: IDX_SEL]);
    ne = '{valid: 1'b1, tag: s[ADDR_LEN-1:3+IDX_SEL], slot: s[2], target: d};
    pick = -1;
    for (int w = 0; w < WAYS; w++)
      if (pick < 0 && mdl[st][w].valid && mdl[st][w].tag == ne.tag && mdl[st][w].slot == ne.slot) pick = w;
    for (int w = 0; w < WAYS; w++)
      if (pick < 0 && !mdl[st][w].valid) pick = w;
    if (pick < 0) begin
      pick = vptr[st];
      vptr[st] = (vptr[st] + 1) % WAYS;
    end
    mdl[st][pick] = ne;
  endtask

  task automatic model_step(input logic [31:0] p, input bit i2, input bit w, input logic [31:0] s,
                            input logic [31:0] d, input bit f, output exp_t e);
    e = '{hit: 1'b0, slot: 1'b0, addr: '0, busy: 1'b0};
    if (busy_left > 0) begin
      busy_left--;
    end else if (f && FLUSH_EN) begin
      model_clear();
      busy_left = SETS;
    end else begin
      model_lookup(p, i2, e);
      if (w) model_write(s, d);
    end
    e.busy = (busy_left > 0);
  endtask

  task automatic cyc(input logic [31:0] p, input bit i2, input bit w, input logic [31:0] s,
                     input logic [31:0] d, input bit f, input bit use_c = 1'b0, input bit c_hit = 1'b0,
                     input bit c_slot = 1'b0, input logic [31:0] c_addr = '0);
    exp_t e;
    pc = p; invalid2 = i2; we = w; jmpsrc = s; jmpdst = d; flush = f;
    @(posedge clk);
    model_step(p, i2, w, s, d, f, e);
    if (use_c) begin
      e.hit = c_hit; e.slot = c_slot; e.addr = c_addr;
    end
    expq.push_back(e);
    #1;
    we = 1'b0; flush = 1'b0;
  endtask

  task automatic look(input logic [31:0] p, input bit i2, input bit c_hit, input bit c_slot, input logic [31:0] c_addr);
    cyc(p, i2, 1'b0, '0, '0, 1'b0, 1'b1, c_hit, c_slot, c_addr);
  endtask

  task automatic wr(input logic [31:0] s, input logic [31:0] d);
    cyc(32'h0, 1'b0, 1'b1, s, d, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  function automatic logic [31:0] raddr();
    return (32'($urandom_range(0, 3)) << (3 + IDX_SEL)) | (32'($urandom_range(0, 3)) << 3) |
           (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset && expq.size() > 0) begin
      e = expq.pop_front();
      chk("busy", 32'(busy), 32'(e.busy));
      chk("hit", 32'(hit), 32'(e.hit));
      if (e.hit) begin
        chk("hit_slot", 32'(hit_slot), 32'(e.slot));
        chk("jmpaddr", jmpaddr, e.addr);
      end
    end
  end

  logic [31:0] fill_list [6] = '{32'h100, 32'h184, 32'h440, 32'h640, 32'h840, 32'h1000};

  initial begin
    model_clear();
    #2;
    chk("reset_hit", 32'(hit), 32'h0);
    chk("reset_slot", 32'(hit_slot), 32'h0);
    chk("reset_jmpaddr", jmpaddr, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    #20 reset = 1'b1;

    // basic hit, read-before-write, slot-1 prediction and invalid2 masking
    look(32'h100, 0, 0, 0, 0);
    cyc(32'h100, 0, 1, 32'h100, 32'h400, 0, 1, 0, 0, 0);
    look(32'h100, 0, 1, 0, 32'h400);
    cyc(32'h180, 0, 1, 32'h184, 32'h800, 0, 1, 0, 0, 0);
    look(32'h180, 0, 1, 1, 32'h800);
    look(32'h180, 1, 0, 0, 0);
    look(32'h184, 1, 1, 0, 32'h800);
    wr(32'h104, 32'h900);
    look(32'h100, 0, 1, 0, 32'h400);
    look(32'h104, 0, 1, 0, 32'h900);

    // round-robin eviction within one set
    wr(32'h040, 32'hA00); wr(32'h240, 32'hA04); wr(32'h440, 32'hA08);
    look(32'h040, 0, 0, 0, 0);
    look(32'h240, 0, 1, 0, 32'hA04);
    look(32'h440, 0, 1, 0, 32'hA08);
    wr(32'h640, 32'hA0C);
    look(32'h240, 0, 0, 0, 0);
    look(32'h440, 0, 1, 0, 32'hA08);
    look(32'h640, 0, 1, 0, 32'hA0C);
    wr(32'h440, 32'hB00);
    look(32'h440, 0, 1, 0, 32'hB00);
    wr(32'h840, 32'hB04);
    look(32'h440, 0, 0, 0, 0);
    look(32'h640, 0, 1, 0, 32'hA0C);
    look(32'h840, 0, 1, 0, 32'hB04);

    // flush together with a write, lookups during and after the sweep
    cyc(32'h100, 0, 1, 32'h1000, 32'h1234, 1);
    for (int i = 0; i < SETS + 4; i++) cyc(fill_list[i % 6], 0, 0, '0, '0, 0);
    for (int i = 0; i < 6; i++) cyc(fill_list[i], 0, 0, '0, '0, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      cyc(raddr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), raddr(),
          $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 199) == 0));

    // reset in the middle of a flush
    for (int i = 0; i < 20; i++) cyc(raddr(), 0, 1, raddr(), $urandom() & 32'hFFFF_FFFC, 0);
    cyc(32'h0, 0, 0, '0, '0, 1);
    for (int i = 0; i < 10; i++) cyc(raddr(), 0, 0, '0, '0, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midflush_rst_busy", 32'(busy), 32'h0);
    chk("midflush_rst_hit", 32'(hit), 32'h0);
    model_clear();
    busy_left = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    for (int i = 0; i < 20; i++) cyc(raddr(), 0, 0, '0, '0, 0);
    for (int i = 0; i < 10; i++) cyc(raddr(), 0, 1, raddr(), $urandom() & 32'hFFFF_FFFC, 0);
    cyc(raddr(), 0, 0, '0, '0, 1);
    for (int i = 0; i < SETS + 6; i++) cyc(raddr(), 1'($urandom_range(0, 1)), 1, raddr(), $urandom() & 32'hFFFF_FFFC, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised, N-way set-associative branch target buffer for the fetch stage. It covers a two-instruction (8-byte) fetch group and predicts a taken branch in either slot. The lookup is registered with one-cycle latency. Entries are written at branch resolution with per-set round-robin replacement, and a sequenced flush clears the whole table after mispredict recovery or context change.

## Interface
- `ADDR_LEN`, 32: instruction address width.
- `IDX_SEL`, 6: log2 of the set count; index is `pc[3 +: IDX_SEL]`.
- `WAYS`, 2: associativity, power of two, 1..8.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `pc` in `ADDR_LEN`: fetch-group address (bit 2 selects the starting slot).
- `invalid2` in 1: slot 1 of the group is not fetched; suppresses slot-1 hits.
- `hit` out 1: registered prediction valid.
- `hit_slot` out 1: slot of the predicted branch (0 = `pc`, 1 = `pc+4`).
- `jmpaddr` out `ADDR_LEN`: registered predicted target.
- `we` in 1: update request from branch resolution.
- `jmpsrc` in `ADDR_LEN`: resolved branch address.
- `jmpdst` in `ADDR_LEN`: resolved branch target.
- `flush` in 1: start a full-table invalidate (single-cycle pulse).
- `busy` out 1: flush in progress.

## Operation
- Each entry holds `valid`, `tag = addr[ADDR_LEN-1 : 3+IDX_SEL]`, `slot = addr[2]` and `target`.
- Lookup set = `pc` index. A way matches when it is valid, its tag equals the `pc` tag, and one of the following holds:
  - `slot == pc[2]`, or
  - `pc[2] == 0`, `slot == 1` and `!invalid2`.
- Multiple matches: the slot-0 match wins (program order). Among equal slots, the lowest way index wins.
- Update with `we`:
  - Target set = `jmpsrc` index.
  - If a valid way has an equal tag and slot, overwrite its target.
  - Otherwise allocate the lowest-index invalid way. If no way is invalid, allocate the way at the set's victim pointer, then increment the pointer mod `WAYS`.
  - The pointer advances only on replacement of a valid entry.
- FSM has two states, IDLE and FLUSH:
  - IDLE→FLUSH on `flush`, with the sweep counter set to 0.
  - In FLUSH, one set is cleared per cycle (all valid bits and its victim pointer).
  - FLUSH→IDLE after set `2^IDX_SEL-1` is cleared.
  - `busy=1` exactly while in FLUSH.
- During FLUSH: `we` is dropped, `hit` is forced to 0, and further `flush` pulses are ignored.
- `flush` and `we` in the same IDLE cycle: flush wins and the write is dropped.
- `WAYS == 1`: the victim pointer is absent and the single way is always overwritten.

## Timing
- Lookup: `pc` sampled at edge t; `hit`, `hit_slot` and `jmpaddr` are valid after edge t and held until the next edge.
- Update: `we` sampled at edge t. A lookup sampled at edge t+1 or later sees the new entry. A same-set lookup sampled at edge t sees old contents (read-before-write).
- Flush: pulse sampled at edge t. The table is fully invalid and `busy` falls after edge t+2^IDX_SEL.
- Reset (asynchronous assert, at any time including mid-flush):
  - All valid bits = 0 and victim pointers = 0.
  - FSM = IDLE and sweep counter = 0.
  - `hit`, `hit_slot`, `jmpaddr` and `busy` = 0.
- Deassertion is synchronised externally. The tag and target arrays need no reset.

## Configuration
- `BTB_FLUSH_EN` defined: the FSM, sweep counter and `flush` behaviour are compiled in as above.
- `BTB_FLUSH_EN` undefined:
  - `flush` is ignored and `busy` is tied to 0.
  - No FSM or counter is built.
  - Invalidation happens only through reset.

## Structure
- Package `btb_pkg` holds:
  - the entry struct/typedef (valid, tag, slot, target);
  - the FSM state enum;
  - helper functions `btb_idx(addr)` and `btb_tag(addr)`.
- Sub-module `btb_way`: one way's storage per instance, with registered read, write port and per-set valid clear.
  - `WAYS` instances are generated.
  - Hit priority and replacement logic live in the top level.

## Test plan
- Reset, then look up `pc=0x100` → `hit=0`. Write `jmpsrc=0x100`, `jmpdst=0x400`; next lookup of 0x100 → `hit=1`, `hit_slot=0`, `jmpaddr=0x400`.
- Write `jmpsrc=0x104`, `jmpdst=0x800`; look up `pc=0x100` with `invalid2=0` → `hit_slot=1`, `jmpaddr=0x800`. Same lookup with `invalid2=1` → `hit=0`.
- `WAYS=2`: write three sources mapping to the same set (0x100, 0x100+2^(3+IDX_SEL), 0x100+2·2^(3+IDX_SEL)) → the first is evicted and the latter two hit. A fourth conflicting write evicts the second.
- Lookup and write to the same set at the same edge → the lookup returns the old miss; the lookup at the next edge hits.
- Fill entries, pulse `flush` together with `we` → `busy` is high for 2^IDX_SEL cycles, the write is dropped, `hit=0` throughout, and all lookups miss afterwards.
- Assert `reset` mid-flush → `busy` and `hit` go to 0 immediately. After release, lookups miss and a new `flush` runs its full length.
